// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus between the fetch unit, its instruction memory and the
// downstream decode stage.
//
// Handshake: ir_valid is the valid of the fetch->decode channel and stall is
// its inverted ready. A transfer completes on a rising edge where
// ir_valid=1 and stall=0. While stall=1, ir, pc_out and ir_valid hold
// unchanged. br_taken overrides stall and squashes the held instruction.
// im_addr/im_data form a combinational read port with no handshake.
interface fetch_unit_if;
  logic [9:0]  im_addr;
  logic [15:0] im_data;
  logic        stall;
  logic        br_taken;
  logic [9:0]  br_target;
  logic [15:0] ir;
  logic        ir_valid;
  logic [9:0]  pc_out;
  logic        halted;

  // Seen from the fetch unit.
  modport master (
    input  im_data, stall, br_taken, br_target,
    output im_addr, ir, ir_valid, pc_out, halted
  );

  // Seen from the memory/decode side.
  modport slave (
    output im_data, stall, br_taken, br_target,
    input  im_addr, ir, ir_valid, pc_out, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: single-cycle instruction fetch with branch redirect and an
// optional halt instruction.
// The macro FETCH_HALT_EN enables halt detection. When it is undefined,
// halt-opcode words are ordinary instructions, halted is held at 0, and the
// FSM never leaves RUN.
// dbg_state_o exposes the FSM state (0=RUN, 1=HALT).
module fetch_unit #(
  parameter logic [9:0] RESET_PC    = 10'd0,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus,
  output logic          dbg_state_o
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

`ifdef FETCH_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [9:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic [9:0]  pc_out_q, pc_out_d;
  logic        halted_q, halted_d;
  logic        halt_req;

  // A fetched word is a halt only when halt detection is built in.
  assign halt_req = HALT_EN & (bus.im_data[15:12] == HALT_OPCODE);

  // State register and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
      pc_out_q   <= 10'd0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc_out_q   <= pc_out_d;
      halted_q   <= halted_d;
    end
  end

  // Next-state logic. A branch beats a stall. A halt word loads like any
  // other instruction but freezes the pc on its own address.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pc_out_d   = pc_out_q;
    halted_d   = halted_q;
    case (state_q)
      S_RUN: begin
        if (bus.br_taken) begin
          pc_d       = bus.br_target;
          ir_d       = 16'h0000;
          ir_valid_d = 1'b0;
        end else if (!bus.stall) begin
          ir_d       = bus.im_data;
          pc_out_d   = pc_q;
          ir_valid_d = 1'b1;
          if (halt_req) begin
            state_d = S_HALT;
          end else begin
            pc_d = pc_q + 10'd1;
          end
        end
      end
      S_HALT: begin
        // Everything holds except the flag and the valid. Only reset leaves HALT.
        ir_valid_d = 1'b0;
        halted_d   = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  assign bus.im_addr  = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.pc_out   = pc_out_q;
  assign bus.halted   = halted_q & HALT_EN;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a reference model of
// the fetch unit. Captured instructions go through an expected queue.
// The bench follows FETCH_HALT_EN the same way the design does.
module tb_fetch_unit;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  logic rst2;
  logic dbg;
  logic dbg2;

  fetch_unit_if fu_if ();
  fetch_unit_if fu2_if ();

  logic [15:0] mem [0:1023];

  fetch_unit u_dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (fu_if.master),
    .dbg_state_o (dbg)
  );

  fetch_unit #(.RESET_PC(10'd1022)) u_dut2 (
    .clk         (clk),
    .rst         (rst2),
    .bus         (fu2_if.master),
    .dbg_state_o (dbg2)
  );

  assign fu_if.im_data  = mem[fu_if.im_addr];
  assign fu2_if.im_data = {6'd0, fu2_if.im_addr};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- model and scoreboard ----------------
  logic [9:0]  m_pc;
  logic [9:0]  m_pcout;
  logic [15:0] m_ir;
  logic        m_valid;
  logic        m_halt_st;
  logic        m_halted;
  logic [25:0] exp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 10'd0;
    m_pcout   = 10'd0;
    m_ir      = 16'h0000;
    m_valid   = 1'b0;
    m_halt_st = 1'b0;
    m_halted  = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".im_addr"},  32'(fu_if.im_addr),  32'(m_pc));
    chk({tag, ".ir"},       32'(fu_if.ir),       32'(m_ir));
    chk({tag, ".ir_valid"}, 32'(fu_if.ir_valid), 32'(m_valid));
    chk({tag, ".pc_out"},   32'(fu_if.pc_out),   32'(m_pcout));
    chk({tag, ".halted"},   32'(fu_if.halted),   32'(m_halted));
    chk({tag, ".state"},    32'(dbg),            32'(m_halt_st));
  endtask

  // ---------------- driver ----------------
  // Drive one cycle's inputs, advance the model, then check after the edge.
  task automatic step(input string tag, input logic s, input logic b, input logic [9:0] t);
    logic        cap;
    logic [15:0] w;
    logic [25:0] e;
    fu_if.stall     = s;
    fu_if.br_taken  = b;
    fu_if.br_target = t;
    cap = 1'b0;
    w   = mem[m_pc];
    if (m_halt_st) begin
      m_valid  = 1'b0;
      m_halted = 1'b1;
    end else if (b) begin
      m_pc    = t;
      m_ir    = 16'h0000;
      m_valid = 1'b0;
    end else if (!s) begin
      cap = 1'b1;
      exp_q.push_back({m_pc, w});
      m_ir    = w;
      m_pcout = m_pc;
      m_valid = 1'b1;
      if (HALT_EN && (w[15:12] == 4'hF)) m_halt_st = 1'b1;
      else m_pc = m_pc + 10'd1;
    end
    @(posedge clk);
    #1;
    if (cap) begin
      e = exp_q.pop_front();
      chk({tag, ".sb_pc"}, 32'(fu_if.pc_out), 32'(e[25:16]));
      chk({tag, ".sb_ir"}, 32'(fu_if.ir),     32'(e[15:0]));
    end
    check_all(tag);
  endtask

  // Reset pulse shorter than half a clock, placed between edges.
  task automatic reset_pulse(input string tag);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    chk({tag, ".async_ir"},   32'(fu_if.ir),      32'h0);
    chk({tag, ".async_addr"}, 32'(fu_if.im_addr), 32'h0);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [9:0] exp2 [0:2];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
    rst              = 1'b0;
    rst2             = 1'b0;
    fu_if.stall      = 1'b0;
    fu_if.br_taken   = 1'b0;
    fu_if.br_target  = 10'd0;
    fu2_if.stall     = 1'b0;
    fu2_if.br_taken  = 1'b0;
    fu2_if.br_target = 10'd0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Free run: after three edges ir=2, pc_out=2, im_addr=3.
    step("run0", 1'b0, 1'b0, 10'd0);
    step("run1", 1'b0, 1'b0, 10'd0);
    step("run2", 1'b0, 1'b0, 10'd0);
    chk("run3.ir", 32'(fu_if.ir), 32'h2);
    chk("run3.addr", 32'(fu_if.im_addr), 32'd3);
    step("run3", 1'b0, 1'b0, 10'd0);
    step("run4", 1'b0, 1'b0, 10'd0);

    // pc=5: stall for four edges, then capture mem[5].
    chk("stall.pc", 32'(fu_if.im_addr), 32'd5);
    for (int i = 0; i < 4; i++) step("stall", 1'b1, 1'b0, 10'd0);
    step("unstall", 1'b0, 1'b0, 10'd0);
    chk("unstall.ir", 32'(fu_if.ir), 32'h5);
    step("to7", 1'b0, 1'b0, 10'd0);

    // pc=7: branch together with stall; branch wins.
    step("br", 1'b1, 1'b1, 10'h200);
    chk("br.addr", 32'(fu_if.im_addr), 32'h200);
    step("br_tgt", 1'b0, 1'b0, 10'd0);
    chk("br_tgt.ir", 32'(fu_if.ir), 32'h200);

    // Random mix of stalls and branches over plain memory.
    for (int i = 0; i < 40; i++)
      step("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           10'($urandom_range(0, 1023)));

    // Halt word at address 4; held behind a stall first.
    reset_pulse("rst_run");
    mem[4] = 16'hF000;
    for (int i = 0; i < 4; i++) step("h_run", 1'b0, 1'b0, 10'd0);
    step("h_stall", 1'b1, 1'b0, 10'd0);
    step("h_stall", 1'b1, 1'b0, 10'd0);
    chk("h_stall.halted", 32'(fu_if.halted), 32'd0);
    step("h_cap", 1'b0, 1'b0, 10'd0);
    chk("h_cap.ir", 32'(fu_if.ir), 32'hF000);
    chk("h_cap.pc_out", 32'(fu_if.pc_out), 32'd4);
    chk("h_cap.addr", 32'(fu_if.im_addr), HALT_EN ? 32'd4 : 32'd5);
    for (int i = 0; i < 10; i++) step("h_hold", 1'b0, i[0], 10'h155);
    chk("h_hold.halted", 32'(fu_if.halted), 32'(HALT_EN));

    // Async reset while halted (or running), then the first capture.
    reset_pulse("rst_halt");
    mem[4] = 16'h0004;
    step("post_rst", 1'b0, 1'b0, 10'd0);
    chk("post_rst.ir", 32'(fu_if.ir), 32'h0);

    // Second instance: RESET_PC=1022, wrap across 1023 -> 0.
    exp2[0] = 10'd1022;
    exp2[1] = 10'd1023;
    exp2[2] = 10'd0;
    rst2 = 1'b1;
    chk("wrap.start", 32'(fu2_if.im_addr), 32'd1022);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("wrap.pc_out", 32'(fu2_if.pc_out), 32'(exp2[i]));
      chk("wrap.valid", 32'(fu2_if.ir_valid), 32'd1);
    end
    chk("wrap.addr", 32'(fu2_if.im_addr), 32'd1);
    chk("wrap.state", 32'(dbg2), 32'd0);
    chk("wrap.halted", 32'(fu2_if.halted), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
